// File: rtl/syn_gpu_job_lb_mstr.sv
// ----------------------------------------------------------------------------
// syn_gpu_job_lb_mstr
// Local-bus master that turns one job-descriptor handshake into a sequence of
// LB writes into the GPU core register file. After reset, the first job also
// enables the core through the CONTROL register. Every job writes
// JOB_BFFR_1..7 and then JOB_BFFR_0. The JOB_BFFR_0 write is the action write
// that starts the job.
//
// Optional feature, controlled by the macro SYN_GPU_JOB_MSTR_POLL_EN:
//   defined   - after the JOB_BFFR_0 ack, STATUS is polled until bit 0 reads 0.
//               Polls are spaced by P_POLL_GAP idle cycles and limited to
//               P_POLL_MAX attempts.
//   undefined - there are no poll states, lb_rd_en is tied low, and job_done
//               follows the JOB_BFFR_0 ack directly.
//
// LB protocol: a strobe is high for exactly one cycle. The master then waits
// for the matching valid. The next strobe goes out the cycle after that ack.
// Address and write data hold steady from the strobe until the ack.
// ----------------------------------------------------------------------------
module syn_gpu_job_lb_mstr #(
  parameter int                     P_LB_ADDR_W      = 8,
  parameter int                     P_LB_DATA_W      = 32,
  parameter logic [P_LB_ADDR_W-1:0] P_CTRL_ADDR      = 'h00,
  parameter logic [P_LB_ADDR_W-1:0] P_STATUS_ADDR    = 'h01,
  parameter logic [P_LB_ADDR_W-1:0] P_BFFR_BASE_ADDR = 'h02,
  parameter int                     P_ACK_TMO        = 16,
  parameter int                     P_POLL_GAP       = 4,
  parameter int                     P_POLL_MAX       = 1024
) (
  input  logic                   clk_ir,
  input  logic                   rst_sync,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [1:0]             job_action,
  input  logic [1:0]             job_shape,
  input  logic [15:0]            job_x0,
  input  logic [15:0]            job_y0,
  input  logic [15:0]            job_x1,
  input  logic [15:0]            job_y1,
  input  logic [15:0]            job_color,
  input  logic [3:0]             job_width,
  output logic                   job_done,
  output logic                   job_err,
  output logic                   busy,
  output logic                   lb_wr_en,
  output logic                   lb_rd_en,
  output logic [P_LB_ADDR_W-1:0] lb_addr,
  output logic [P_LB_DATA_W-1:0] lb_wr_data,
  input  logic                   lb_wr_valid,
  input  logic                   lb_rd_valid,
  input  logic [P_LB_DATA_W-1:0] lb_rd_data
);

  localparam int ACK_W = $clog2(P_ACK_TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EN_WR,
    S_EN_ACK,
    S_BF_WR,
    S_BF_ACK,
    S_POLL_RD,
    S_POLL_ACK,
    S_POLL_GAP
  } state_t;

  typedef struct packed {
    logic [1:0]  action;
    logic [1:0]  shape;
    logic [15:0] x0;
    logic [15:0] y0;
    logic [15:0] x1;
    logic [15:0] y1;
    logic [15:0] color;
    logic [3:0]  width;
  } job_t;

  state_t           state;
  job_t             job_q;
  job_t             job_in;
  logic             en_done;
  logic [2:0]       idx;
  logic [2:0]       idx_nxt;
  logic [ACK_W-1:0] ack_cnt;

  assign job_in = '{action: job_action, shape: job_shape,
                    x0: job_x0, y0: job_y0, x1: job_x1, y1: job_y1,
                    color: job_color, width: job_width};

  // JOB_BFFR_n order is 1..7 and then 0; the 3-bit index wraps 7 -> 0.
  assign idx_nxt = idx + 3'd1;

  // Register address of JOB_BFFR_n.
  function automatic logic [P_LB_ADDR_W-1:0] bf_addr(input logic [2:0] n);
    return P_BFFR_BASE_ADDR + P_LB_ADDR_W'(n);
  endfunction

  // Field carried by JOB_BFFR_n, zero-extended to the bus width.
  function automatic logic [P_LB_DATA_W-1:0] bf_data(input logic [2:0] n,
                                                     input job_t       j);
    logic [P_LB_DATA_W-1:0] d;
    // NOTE: give d a value before the case so that no path through this
    // decode can leave it unassigned, which would infer a latch.
    d = '0;
    case (n)
      3'd0:    d = P_LB_DATA_W'(j.action);
      3'd1:    d = P_LB_DATA_W'(j.shape);
      3'd2:    d = P_LB_DATA_W'(j.x0);
      3'd3:    d = P_LB_DATA_W'(j.y0);
      3'd4:    d = P_LB_DATA_W'(j.x1);
      3'd5:    d = P_LB_DATA_W'(j.y1);
      3'd6:    d = P_LB_DATA_W'(j.color);
      default: d = P_LB_DATA_W'(j.width);
    endcase
    return d;
  endfunction

`ifdef SYN_GPU_JOB_MSTR_POLL_EN
  localparam int POLL_W = $clog2(P_POLL_MAX + 1);
  localparam int GAP_W  = $clog2(P_POLL_GAP + 1);

  logic [POLL_W-1:0] poll_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              unused_rd;

  // Only the euclid-busy bit of STATUS matters.
  assign unused_rd = ^lb_rd_data[P_LB_DATA_W-1:1];
`else
  logic unused_rd;

  // Without polling, the read side of the bus and the poll settings are not used.
  assign unused_rd = ^{lb_rd_valid, lb_rd_data, P_STATUS_ADDR, P_POLL_GAP, P_POLL_MAX};
  assign lb_rd_en  = 1'b0;
`endif

  // Job sequencer FSM. Every output is registered here.
  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      state      <= S_IDLE;
      // NOTE: the descriptor register is reset only to keep simulation free of
      // X values. It is always reloaded before use, so it needs no reset to work.
      job_q      <= '0;
      en_done    <= 1'b0;
      idx        <= '0;
      ack_cnt    <= '0;
      job_ready  <= 1'b1;
      job_done   <= 1'b0;
      job_err    <= 1'b0;
      busy       <= 1'b0;
      lb_wr_en   <= 1'b0;
      lb_addr    <= '0;
      lb_wr_data <= '0;
`ifdef SYN_GPU_JOB_MSTR_POLL_EN
      lb_rd_en   <= 1'b0;
      poll_cnt   <= '0;
      gap_cnt    <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. The pulse
      // defaults below are then overridden by later assignments in this block.
      job_done <= 1'b0;
      job_err  <= 1'b0;
      lb_wr_en <= 1'b0;
`ifdef SYN_GPU_JOB_MSTR_POLL_EN
      lb_rd_en <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (job_valid && job_ready) begin
            job_q     <= job_in;
            job_ready <= 1'b0;
            busy      <= 1'b1;
            ack_cnt   <= '0;
            idx       <= 3'd1;
            lb_wr_en  <= 1'b1;
            if (!en_done) begin
              state      <= S_EN_WR;
              lb_addr    <= P_CTRL_ADDR;
              lb_wr_data <= P_LB_DATA_W'(1);
            end else begin
              state      <= S_BF_WR;
              lb_addr    <= bf_addr(3'd1);
              lb_wr_data <= bf_data(3'd1, job_in);
            end
          end
        end

        S_EN_WR: state <= S_EN_ACK;

        S_EN_ACK: begin
          if (lb_wr_valid) begin
            en_done    <= 1'b1;
            ack_cnt    <= '0;
            state      <= S_BF_WR;
            lb_wr_en   <= 1'b1;
            lb_addr    <= bf_addr(idx);
            lb_wr_data <= bf_data(idx, job_q);
          end else if (ack_cnt == ACK_W'(P_ACK_TMO - 1)) begin
            state     <= S_IDLE;
            job_err   <= 1'b1;
            job_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end

        S_BF_WR: state <= S_BF_ACK;

        S_BF_ACK: begin
          if (lb_wr_valid) begin
            ack_cnt <= '0;
            if (idx == 3'd0) begin
`ifdef SYN_GPU_JOB_MSTR_POLL_EN
              state    <= S_POLL_RD;
              lb_rd_en <= 1'b1;
              lb_addr  <= P_STATUS_ADDR;
              poll_cnt <= POLL_W'(1);
`else
              state     <= S_IDLE;
              job_done  <= 1'b1;
              job_ready <= 1'b1;
              busy      <= 1'b0;
`endif
            end else begin
              idx        <= idx_nxt;
              state      <= S_BF_WR;
              lb_wr_en   <= 1'b1;
              lb_addr    <= bf_addr(idx_nxt);
              lb_wr_data <= bf_data(idx_nxt, job_q);
            end
          end else if (ack_cnt == ACK_W'(P_ACK_TMO - 1)) begin
            state     <= S_IDLE;
            job_err   <= 1'b1;
            job_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end

`ifdef SYN_GPU_JOB_MSTR_POLL_EN
        S_POLL_RD: state <= S_POLL_ACK;

        S_POLL_ACK: begin
          if (lb_rd_valid) begin
            ack_cnt <= '0;
            if (!lb_rd_data[0]) begin
              state     <= S_IDLE;
              job_done  <= 1'b1;
              job_ready <= 1'b1;
              busy      <= 1'b0;
            end else if (poll_cnt == POLL_W'(P_POLL_MAX)) begin
              state     <= S_IDLE;
              job_err   <= 1'b1;
              job_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state   <= S_POLL_GAP;
              gap_cnt <= '0;
            end
          end else if (ack_cnt == ACK_W'(P_ACK_TMO - 1)) begin
            state     <= S_IDLE;
            job_err   <= 1'b1;
            job_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end

        S_POLL_GAP: begin
          if (gap_cnt == GAP_W'(P_POLL_GAP - 1)) begin
            state    <= S_POLL_RD;
            lb_rd_en <= 1'b1;
            lb_addr  <= P_STATUS_ADDR;
            poll_cnt <= poll_cnt + 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
`endif

        default: begin
          state     <= S_IDLE;
          job_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_syn_gpu_job_lb_mstr.sv
// ----------------------------------------------------------------------------
// tb_syn_gpu_job_lb_mstr
// Directed bench for syn_gpu_job_lb_mstr. The LB slave model acks one cycle
// after each strobe. It can refuse to ack one chosen address, and it can report
// STATUS busy for a set number of polls. A negedge monitor logs strobes,
// handshakes and pulses with their cycle numbers. Checks compare those logs
// with hand-computed sequences.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_syn_gpu_job_lb_mstr;

`ifdef SYN_GPU_JOB_MSTR_POLL_EN
  localparam int POLL_LAT = 2;
`else
  localparam int POLL_LAT = 0;
`endif

  typedef struct {
    logic [1:0]  action;
    logic [1:0]  shape;
    logic [15:0] x0;
    logic [15:0] y0;
    logic [15:0] x1;
    logic [15:0] y1;
    logic [15:0] color;
    logic [3:0]  width;
  } desc_t;

  logic        clk_ir = 1'b0;
  logic        rst_sync = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [1:0]  job_action = '0;
  logic [1:0]  job_shape = '0;
  logic [15:0] job_x0 = '0, job_y0 = '0, job_x1 = '0, job_y1 = '0, job_color = '0;
  logic [3:0]  job_width = '0;
  logic        job_done, job_err, busy, lb_wr_en, lb_rd_en;
  logic [7:0]  lb_addr;
  logic [31:0] lb_wr_data;
  logic        lb_wr_valid = 1'b0;
  logic        lb_rd_valid = 1'b0;
  logic [31:0] lb_rd_data = '0;

  syn_gpu_job_lb_mstr dut (
    .clk_ir(clk_ir), .rst_sync(rst_sync),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_action(job_action), .job_shape(job_shape),
    .job_x0(job_x0), .job_y0(job_y0), .job_x1(job_x1), .job_y1(job_y1),
    .job_color(job_color), .job_width(job_width),
    .job_done(job_done), .job_err(job_err), .busy(busy),
    .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en),
    .lb_addr(lb_addr), .lb_wr_data(lb_wr_data),
    .lb_wr_valid(lb_wr_valid), .lb_rd_valid(lb_rd_valid), .lb_rd_data(lb_rd_data)
  );

  always #5 clk_ir = ~clk_ir;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int          wr_cyc_q[$];
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          rd_cyc_q[$];
  logic [7:0]  rd_addr_q[$];
  int          done_q[$];
  int          err_q[$];
  int          hs_q[$];
  int          rd_total = 0;
  logic        both_seen = 1'b0;
  logic        rdy_busy = 1'b0;

  // Slave controls.
  logic        nack_en = 1'b0;
  logic [7:0]  nack_addr = '0;
  int          busy_polls = 0;
  logic        wr_pend = 1'b0;
  logic        rd_pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_ir);
    #1;
  endtask

  task automatic clear_logs();
    wr_cyc_q = {}; wr_addr_q = {}; wr_data_q = {};
    rd_cyc_q = {}; rd_addr_q = {};
    done_q = {}; err_q = {}; hs_q = {};
  endtask

  task automatic set_inputs(input desc_t d);
    job_action = d.action; job_shape = d.shape;
    job_x0 = d.x0; job_y0 = d.y0; job_x1 = d.x1; job_y1 = d.y1;
    job_color = d.color; job_width = d.width;
  endtask

  function automatic logic [31:0] exp_data(input desc_t d, input int n);
    case (n)
      0: return {30'd0, d.action};
      1: return {30'd0, d.shape};
      2: return {16'd0, d.x0};
      3: return {16'd0, d.y0};
      4: return {16'd0, d.x1};
      5: return {16'd0, d.y1};
      6: return {16'd0, d.color};
      default: return {28'd0, d.width};
    endcase
  endfunction

  // Raise job_valid and wait (bounded) for the handshake.
  task automatic start_job(input desc_t d, input bit hold);
    int n0;
    bit seen;
    set_inputs(d);
    job_valid = 1'b1;
    n0 = hs_q.size();
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (hs_q.size() > n0) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("handshake_timeout", 0, 1);
    if (!hold) job_valid = 1'b0;
  endtask

  // Wait (bounded) for the next job_done or job_err pulse.
  task automatic wait_end(input int budget);
    int nd, ne;
    bit seen;
    nd = done_q.size();
    ne = err_q.size();
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_q.size() > nd || err_q.size() > ne) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("end_timeout", 0, 1);
  endtask

  // Cycle counter: cycle N is the interval after the Nth rising edge.
  initial forever begin
    @(posedge clk_ir);
    cyc++;
  end

  // Monitor: sample outputs mid-cycle.
  initial forever begin
    @(negedge clk_ir);
    if (lb_wr_en) begin
      wr_cyc_q.push_back(cyc); wr_addr_q.push_back(lb_addr); wr_data_q.push_back(lb_wr_data);
    end
    if (lb_rd_en) begin
      rd_cyc_q.push_back(cyc); rd_addr_q.push_back(lb_addr); rd_total++;
    end
    if (lb_wr_en && lb_rd_en) both_seen = 1'b1;
    if (job_ready && busy) rdy_busy = 1'b1;
    if (job_done) done_q.push_back(cyc);
    if (job_err) err_q.push_back(cyc);
    if (job_valid && job_ready && !rst_sync) hs_q.push_back(cyc);
  end

  // LB slave: the ack is high during the cycle after the strobe.
  initial forever begin
    @(negedge clk_ir);
    lb_wr_valid = wr_pend;
    lb_rd_valid = rd_pend;
    lb_rd_data  = rd_pend ? {31'd0, (busy_polls > 0)} : 32'd0;
    if (rd_pend && busy_polls > 0) busy_polls--;
    wr_pend = lb_wr_en && !(nack_en && lb_addr == nack_addr);
    rd_pend = lb_rd_en;
  end

  desc_t da, db, dc, dd, de, df, dg, dh;
  int    hs0, d1, s_err;

  initial begin
    da = '{action: 2'd2, shape: 2'd1, x0: 16'h0011, y0: 16'h0022, x1: 16'h0133,
           y1: 16'h0244, color: 16'hF81F, width: 4'd5};
    db = '{action: 2'd1, shape: 2'd3, x0: 16'hFFFF, y0: 16'h0000, x1: 16'h8000,
           y1: 16'h7FFF, color: 16'h07E0, width: 4'hF};
    dc = '{action: 2'd3, shape: 2'd2, x0: 16'h1234, y0: 16'h5678, x1: 16'h9ABC,
           y1: 16'hDEF0, color: 16'h001F, width: 4'd1};
    dd = '{action: 2'd0, shape: 2'd1, x0: 16'hA5A5, y0: 16'h5A5A, x1: 16'h0F0F,
           y1: 16'hF0F0, color: 16'hFFFF, width: 4'd9};
    de = '{action: 2'd1, shape: 2'd0, x0: 16'd10, y0: 16'd20, x1: 16'd30,
           y1: 16'd40, color: 16'd50, width: 4'd2};
    df = '{action: 2'd2, shape: 2'd2, x0: 16'd1, y0: 16'd2, x1: 16'd3,
           y1: 16'd4, color: 16'd5, width: 4'd6};
    dg = '{action: 2'd3, shape: 2'd3, x0: 16'd7, y0: 16'd8, x1: 16'd9,
           y1: 16'd10, color: 16'd11, width: 4'd12};
    dh = '{action: 2'd1, shape: 2'd1, x0: 16'h0101, y0: 16'h0202, x1: 16'h0303,
           y1: 16'h0404, color: 16'h0505, width: 4'd3};

    // ---- Reset state ----
    rst_sync = 1'b1;
    repeat (3) tick();
    chk("rst_job_ready", job_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", lb_wr_en, 0);
    chk("rst_rd_en", lb_rd_en, 0);
    chk("rst_done_err", {job_done, job_err}, 0);
    chk("rst_addr", lb_addr, 0);
    chk("rst_wr_data", lb_wr_data, 0);
    rst_sync = 1'b0;
    tick();

    // ---- 1: first job writes CONTROL then BFFR_1..7, BFFR_0 ----
    clear_logs();
    start_job(da, 0);
    wait_end(200);
    chk("t1_wr_count", wr_cyc_q.size(), 9);
    chk("t1_done_count", done_q.size(), 1);
    if (wr_cyc_q.size() == 9) begin
      chk("t1_ctrl_addr", wr_addr_q[0], 8'h00);
      chk("t1_ctrl_data", wr_data_q[0], 32'h1);
      for (int k = 1; k <= 7; k++) begin
        chk($sformatf("t1_bf%0d_addr", k), wr_addr_q[k], 8'(8'h02 + k));
        chk($sformatf("t1_bf%0d_data", k), wr_data_q[k], exp_data(da, k));
      end
      chk("t1_bf0_addr", wr_addr_q[8], 8'h02);
      chk("t1_bf0_data", wr_data_q[8], exp_data(da, 0));
    end

    // ---- 2: second job skips CONTROL; fixed latency ----
    tick();
    clear_logs();
    start_job(db, 0);
    wait_end(200);
    chk("t2_wr_count", wr_cyc_q.size(), 8);
    if (wr_cyc_q.size() == 8 && hs_q.size() == 1 && done_q.size() == 1) begin
      hs0 = hs_q[0];
      chk("t2_first_addr", wr_addr_q[0], 8'h03);
      for (int k = 0; k < 8; k++)
        chk($sformatf("t2_wr%0d_cycle", k), wr_cyc_q[k] - hs0, 1 + 2 * k);
      chk("t2_last_data", wr_data_q[7], exp_data(db, 0));
      chk("t2_done_latency", done_q[0] - hs0, 17 + POLL_LAT);
    end else begin
      chk("t2_log_shape", {hs_q.size(), done_q.size()}, {32'd1, 32'd1});
    end

    // ---- 3: job_valid held high; back-to-back accept ----
    tick();
    clear_logs();
    start_job(dc, 1);
    set_inputs(dd);             // inputs change after the handshake; C must stay latched
    wait_end(200);
    chk("t3_hs_count_at_done1", hs_q.size(), 2);
    if (hs_q.size() == 2 && done_q.size() == 1) begin
      d1 = done_q[0];
      chk("t3_second_hs_cycle", hs_q[1], d1);
    end else begin
      d1 = 0;
    end
    job_valid = 1'b0;
    wait_end(200);
    chk("t3_wr_count", wr_cyc_q.size(), 16);
    if (wr_cyc_q.size() == 16) begin
      chk("t3_c_last_data", wr_data_q[7], exp_data(dc, 0));
      chk("t3_c_x0", wr_data_q[1], exp_data(dc, 2));
      chk("t3_d_first_cycle", wr_cyc_q[8], d1 + 1);
      chk("t3_d_first_data", wr_data_q[8], exp_data(dd, 1));
      chk("t3_d_last_data", wr_data_q[15], exp_data(dd, 0));
    end

    // ---- 4: BFFR_3 never acked -> timeout error ----
    tick();
    clear_logs();
    nack_en = 1'b1;
    nack_addr = 8'h05;
    start_job(de, 0);
    wait_end(200);
    chk("t4_err_count", err_q.size(), 1);
    chk("t4_done_count", done_q.size(), 0);
    chk("t4_wr_count", wr_cyc_q.size(), 3);
    if (err_q.size() == 1 && wr_cyc_q.size() == 3) begin
      s_err = wr_cyc_q[2];
      chk("t4_nack_addr", wr_addr_q[2], 8'h05);
      chk("t4_err_cycle", err_q[0] - s_err, 17);
    end
    chk("t4_busy_after", busy, 0);
    chk("t4_ready_after", job_ready, 1);
    nack_en = 1'b0;
    tick();
    clear_logs();
    start_job(df, 0);
    wait_end(200);
    chk("t4_next_wr_count", wr_cyc_q.size(), 8);
    if (wr_cyc_q.size() > 0) chk("t4_next_first_addr", wr_addr_q[0], 8'h03);
    chk("t4_next_done", done_q.size(), 1);

`ifdef SYN_GPU_JOB_MSTR_POLL_EN
    // ---- 5: STATUS busy for 3 polls, then idle ----
    tick();
    clear_logs();
    busy_polls = 3;
    start_job(db, 0);
    wait_end(300);
    chk("t5_rd_count", rd_cyc_q.size(), 4);
    chk("t5_done_count", done_q.size(), 1);
    if (rd_cyc_q.size() == 4 && done_q.size() == 1 && wr_cyc_q.size() == 8) begin
      chk("t5_first_rd", rd_cyc_q[0] - wr_cyc_q[7], 2);
      for (int k = 0; k < 4; k++) chk($sformatf("t5_rd%0d_addr", k), rd_addr_q[k], 8'h01);
      for (int k = 1; k < 4; k++)
        chk($sformatf("t5_rd%0d_gap", k), rd_cyc_q[k] - rd_cyc_q[k-1], 6);
      chk("t5_done_cycle", done_q[0] - rd_cyc_q[3], 2);
    end
`endif

    // ---- 6: reset during BF_ACK aborts the job ----
    tick();
    clear_logs();
    start_job(dg, 0);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
        if (wr_cyc_q.size() >= 2) begin
          seen = 1;
          break;
        end
        tick();
      end
      if (!seen) chk("t6_wait_timeout", 0, 1);
    end
    // Now in the cycle after the BFFR_2 strobe, i.e. BF_ACK.
    rst_sync = 1'b1;
    tick();
    rst_sync = 1'b0;
    chk("t6_wr_en", lb_wr_en, 0);
    chk("t6_rd_en", lb_rd_en, 0);
    chk("t6_ready", job_ready, 1);
    chk("t6_busy", busy, 0);
    repeat (30) tick();
    chk("t6_no_pulse", done_q.size() + err_q.size(), 0);
    chk("t6_no_more_wr", wr_cyc_q.size(), 2);
    clear_logs();
    start_job(dh, 0);
    wait_end(200);
    chk("t6_next_wr_count", wr_cyc_q.size(), 9);
    if (wr_cyc_q.size() == 9) begin
      chk("t6_next_ctrl_addr", wr_addr_q[0], 8'h00);
      chk("t6_next_ctrl_data", wr_data_q[0], 32'h1);
      chk("t6_next_bf0_data", wr_data_q[8], exp_data(dh, 0));
    end
    chk("t6_next_done", done_q.size(), 1);

    // ---- Global properties ----
    chk("never_wr_and_rd", both_seen, 0);
    chk("never_ready_while_busy", rdy_busy, 0);
`ifndef SYN_GPU_JOB_MSTR_POLL_EN
    chk("no_rd_without_poll", rd_total, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
